chacha_keystream_xor: RTL and testbench
=======================================

# chacha_keystream_xor

Consumer side of the ChaCha20 block function. Accepts finished 4x4 keystream blocks over a valid/ready handshake into a two-entry ping-pong buffer. Serialises each block into 16 keystream words and XORs them one-for-one with a 32-bit plaintext/ciphertext word stream. The same datapath both encrypts and decrypts; it feeds the Poly1305 tag path and the AEAD output port.

## Interface
- `NUM_BUF`, 2: keystream block buffer entries; fixed at 2 (ping-pong).
- `WORD_W`, 32: word width; must equal `word_t`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `flush` in 1: synchronous clear of buffers and word index (new key/nonce).
- `ks_block` in `word_t[3:0][3:0]`: keystream block from the block function.
- `ks_valid` in 1: `ks_block` is valid.
- `ks_ready` out 1: a buffer entry is free.
- `din` in 32: input data word, little-endian byte packing.
- `din_valid` in 1: `din` is valid.
- `din_last` in 1: `din` is the final word of the message.
- `din_ready` out 1: word accepted this cycle if `din_valid`.
- `dout` out 32: `din ^ keystream word`.
- `dout_valid` out 1: `dout` is valid.
- `dout_last` out 1: registered copy of `din_last`.
- `dout_ready` in 1: downstream accepts `dout`.
- `blocks_used` out 32: count of keystream blocks retired (stats).
- `words_xored` out 32: count of words emitted (stats).

## Operation
- Buffer state: `full[1:0]`, write pointer `wp`, read pointer `rp`, word index `idx` (4 bits, 0..15).
- Word k of a block is `ks_block[k/4][k%4]` (row-major, RFC 8439 serialisation order).
- Fill:
  - `ks_ready = !full[wp]`.
  - On `ks_valid && ks_ready`: store the block in entry `wp`, set `full[wp]`, toggle `wp`.
- Consume:
  - `din_ready = full[rp] && (!dout_valid || dout_ready)`.
  - On `din_valid && din_ready`: `dout <= din ^ buf[rp][idx]`, `dout_last <= din_last`, `dout_valid <= 1`, `idx <= idx+1`.
- Retire: when `idx==15` or `din_last` is accepted, clear `full[rp]`, toggle `rp`, set `idx <= 0`.
  - On `din_last`, the unused remainder of that block is discarded. No keystream is carried across messages.
- Output hold: when `dout_valid && !dout_ready`, `dout`, `dout_last` and `dout_valid` stay stable. `dout_valid` clears on `dout_ready` unless a new word is accepted in the same cycle.
- Simultaneous fill and retire on different entries in one cycle: both take effect. A freed entry becomes visible through `ks_ready` in the next cycle.
- `flush`: clears `full`, `wp`, `rp`, `idx`, `dout_valid`; counters are not cleared. `flush` has priority over every handshake in the same cycle; a handshake in a flush cycle is dropped.
- Reset mid-message: all state is lost; the upstream must restart the message and the block counter.
- Counters: wrap modulo 2^32.
  - `blocks_used` increments on each retire.
  - `words_xored` increments on each `dout` handshake.

## Timing
- Reset values:
  - `ks_ready=1`, `din_ready=0`, `dout=0`, `dout_valid=0`, `dout_last=0`.
  - `blocks_used=0`, `words_xored=0`, all `full=0`.
- Latency: `ks_valid` handshake to first `din_ready` is 1 cycle.
- Latency: `din` handshake to `dout_valid` is 1 cycle.
- Throughput: 1 word/cycle sustained while a filled entry is available and `dout_ready=1`.
- Block boundary: no bubble when the next entry is already full at retire.
- Empty: `din_ready=0` until a block lands.
- Full (both entries): `ks_ready=0`.

## Configuration
- `CHACHA_KS_STATS_EN` defined: `blocks_used` and `words_xored` counters are implemented as above.
- `CHACHA_KS_STATS_EN` undefined: no counter flops; both outputs are tied to 0.

## Test plan
- RFC 8439 §2.4.2 block (counter=1), `din=0x6964614c` ("Ladi") -> `dout=0x9a352e6e` one cycle later, `dout_last=0`.
- Two blocks preloaded, 32 words streamed with `dout_ready=1` -> 32 consecutive `dout_valid` cycles with no bubble, `blocks_used=2`, `ks_ready` back to 1.
- `din_last` on word 5 of a block, then a new message -> the next word uses word 0 of the second buffered block, `blocks_used=1`.
- `dout_ready` held 0 for 3 cycles mid-stream -> `dout` stable, `din_ready=0`, no word lost or duplicated; all 16 XOR results are correct after release.
- Both entries full, `ks_valid=1` -> `ks_ready=0` and the block is not accepted until a retire.
- `flush` asserted together with `din_valid` and `ks_valid` -> both handshakes dropped, `dout_valid=0`, `ks_ready=1`.
- `rst_n` asserted low mid-block -> all outputs return to their reset values.

Source files
------------

// File: rtl/chacha_keystream_xor.sv
// chacha_keystream_xor
// Consumer side of the ChaCha20 block function. Finished 4x4 keystream
// blocks land in a two-entry ping-pong buffer. Each block is then read out
// as 16 words in row-major order and XORed one-for-one with the 32-bit data
// stream. Encryption and decryption use the same path.
//
// Build option: define CHACHA_KS_STATS_EN to implement the blocks_used /
// words_xored statistics counters. Without it, both outputs are tied to 0
// and no counter flops are built.
module chacha_keystream_xor #(
    parameter int NUM_BUF = 2,
    parameter int WORD_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [3:0][3:0][WORD_W-1:0] ks_block,
    input  logic                        ks_valid,
    output logic                        ks_ready,
    input  logic [WORD_W-1:0]           din,
    input  logic                        din_valid,
    input  logic                        din_last,
    output logic                        din_ready,
    output logic [WORD_W-1:0]           dout,
    output logic                        dout_valid,
    output logic                        dout_last,
    input  logic                        dout_ready,
    output logic [31:0]                 blocks_used,
    output logic [31:0]                 words_xored
);

    typedef logic [3:0][3:0][WORD_W-1:0] block_t;

    // Word k of a block is row k/4, column k%4 (RFC 8439 serialisation order).
    function automatic logic [WORD_W-1:0] ks_word(input block_t blk, input logic [3:0] k);
        ks_word = blk[k[3:2]][k[1:0]];
    endfunction

    // Buffer storage and bookkeeping. NUM_BUF is fixed at 2, so a 1-bit
    // pointer addresses the ping-pong pair.
    block_t              kbuf_q [NUM_BUF];
    block_t              kbuf_d [NUM_BUF];
    logic [NUM_BUF-1:0]  full_q;
    logic [NUM_BUF-1:0]  full_d;
    logic                wp_q;
    logic                wp_d;
    logic                rp_q;
    logic                rp_d;
    logic [3:0]          idx_q;
    logic [3:0]          idx_d;
    logic [WORD_W-1:0]   dout_q;
    logic [WORD_W-1:0]   dout_d;
    logic                dout_valid_q;
    logic                dout_valid_d;
    logic                dout_last_q;
    logic                dout_last_d;

    // Handshake qualifiers; flush masks every handshake in its cycle.
    logic                ks_ready_s;
    logic                din_ready_s;
    logic                fill_s;
    logic                take_s;
    logic                retire_s;
    logic                out_hs_s;

    // Ready signals come straight from state; handshakes are gated by flush.
    always_comb begin
        ks_ready_s  = ~full_q[wp_q];
        din_ready_s = full_q[rp_q] & (~dout_valid_q | dout_ready);
        fill_s      = ks_valid & ks_ready_s & ~flush;
        take_s      = din_valid & din_ready_s & ~flush;
        retire_s    = take_s & ((idx_q == 4'd15) | din_last);
        out_hs_s    = dout_valid_q & dout_ready & ~flush;
    end

    // Next-state for buffer entries: a block is written only into the free entry at wp.
    always_comb begin
        kbuf_d = kbuf_q;
        if (fill_s) begin
            kbuf_d[wp_q] = ks_block;
        end else begin
            kbuf_d = kbuf_q;
        end
    end

    // Next-state for pointers, occupancy, word index and the output register.
    always_comb begin
        full_d       = full_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        if (flush) begin
            // New key/nonce: drop buffered keystream and any pending output.
            full_d       = {NUM_BUF{1'b0}};
            wp_d         = 1'b0;
            rp_d         = 1'b0;
            idx_d        = 4'd0;
            dout_valid_d = 1'b0;
        end else begin
            // Fill and retire always target different entries, so both may apply.
            if (fill_s) begin
                full_d[wp_q] = 1'b1;
                wp_d         = ~wp_q;
            end else begin
                wp_d = wp_q;
            end

            if (retire_s) begin
                // End of block or end of message: leftover keystream is discarded.
                full_d[rp_q] = 1'b0;
                rp_d         = ~rp_q;
                idx_d        = 4'd0;
            end else if (take_s) begin
                idx_d = idx_q + 4'd1;
            end else begin
                idx_d = idx_q;
            end

            if (take_s) begin
                dout_d       = din ^ ks_word(kbuf_q[rp_q], idx_q);
                dout_last_d  = din_last;
                dout_valid_d = 1'b1;
            end else if (out_hs_s) begin
                dout_valid_d = 1'b0;
            end else begin
                dout_valid_d = dout_valid_q;
            end
        end
    end

    // Keystream storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbuf_q <= '{default: '0};
        end else begin
            kbuf_q <= kbuf_d;
        end
    end

    // Control state and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q       <= {NUM_BUF{1'b0}};
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            idx_q        <= 4'd0;
            dout_q       <= {WORD_W{1'b0}};
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            full_q       <= full_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign ks_ready   = ks_ready_s;
    assign din_ready  = din_ready_s;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

`ifdef CHACHA_KS_STATS_EN
    logic [31:0] blocks_used_q;
    logic [31:0] blocks_used_d;
    logic [31:0] words_xored_q;
    logic [31:0] words_xored_d;

    // Statistics: retired blocks and drained output words, both wrapping mod 2^32.
    always_comb begin
        if (retire_s) begin
            blocks_used_d = blocks_used_q + 32'd1;
        end else begin
            blocks_used_d = blocks_used_q;
        end
        if (out_hs_s) begin
            words_xored_d = words_xored_q + 32'd1;
        end else begin
            words_xored_d = words_xored_q;
        end
    end

    // Statistics registers; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_used_q <= 32'd0;
            words_xored_q <= 32'd0;
        end else begin
            blocks_used_q <= blocks_used_d;
            words_xored_q <= words_xored_d;
        end
    end

    assign blocks_used = blocks_used_q;
    assign words_xored = words_xored_q;
`else
    assign blocks_used = 32'd0;
    assign words_xored = 32'd0;
`endif

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Self-checking bench for chacha_keystream_xor. A queue of 16-word keystream
// blocks models the buffer; each accepted data word is XORed with the
// current model block word, and a block is dropped at word 15 or din_last.
module tb_chacha_keystream_xor;

`ifdef CHACHA_KS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [3:0][3:0][31:0] pblk_t;
    typedef logic [31:0] blk16_t [16];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    pblk_t       ks_block;
    logic        ks_valid;
    logic        ks_ready;
    logic [31:0] din;
    logic        din_valid;
    logic        din_last;
    logic        din_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic [31:0] blocks_used;
    logic [31:0] words_xored;

    always #5 clk = ~clk;

    chacha_keystream_xor dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ks_block(ks_block), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .blocks_used(blocks_used), .words_xored(words_xored)
    );

    blk16_t      blkq[$];
    int          widx = 0;
    int unsigned exp_blocks = 0;
    int unsigned exp_words = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] st(input int unsigned v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic make_block(output pblk_t pk, output blk16_t w);
        for (int k = 0; k < 16; k++) begin
            w[k] = $urandom;
            pk[k / 4][k % 4] = w[k];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one block until accepted; the model queue grows on acceptance.
    task automatic push_block(input pblk_t pk, input blk16_t w);
        int  n = 0;
        bit  acc = 1'b0;
        ks_block = pk;
        ks_valid = 1'b1;
        while (!acc && n <= 100) begin
            #1;
            acc = (ks_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!acc) n++;
        end
        ks_valid = 1'b0;
        if (acc) begin
            blkq.push_back(w);
        end else begin
            checks++; errors++;
            $display("FAIL push_timeout ks_ready=%b required=1", ks_ready);
        end
    endtask

    // Offer one data word until accepted; returns the expected dout and stall count.
    task automatic send_word(input logic [31:0] d, input bit last,
                             output logic [31:0] ex, output int waited);
        bit acc = 1'b0;
        waited = 0;
        ex = 32'h0;
        din = d; din_last = last; din_valid = 1'b1;
        while (!acc && waited <= 100) begin
            #1;
            acc = (din_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        din_valid = 1'b0; din_last = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL din_timeout din_ready=%b required=1", din_ready);
        end else if (blkq.size() == 0) begin
            checks++; errors++;
            $display("FAIL accept_empty din_ready=1 required=0");
        end else begin
            ex = d ^ blkq[0][widx];
            widx++;
            exp_words++;
            if (widx == 16 || last) begin
                void'(blkq.pop_front());
                widx = 0;
                exp_blocks++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; ks_valid = 1'b0; ks_block = '0;
        din = 32'h0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ks_ready !== 1'b1) begin errors++; $display("FAIL rst_ks_ready got=%b exp=1", ks_ready); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready got=%b exp=0", din_ready); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL rst_dout_last got=%b exp=0", dout_last); end
        checks++; if (blocks_used !== 32'h0) begin errors++; $display("FAIL rst_blocks got=%0d exp=0", blocks_used); end
        checks++; if (words_xored !== 32'h0) begin errors++; $display("FAIL rst_words got=%0d exp=0", words_xored); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_rfc;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt;
        make_block(pk, w);
        w[0] = 32'hf3514f22;
        pk[0][0] = 32'hf3514f22;
        push_block(pk, w);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rfc_din_ready_latency got=%b exp=1", din_ready); end
        send_word(32'h6964614c, 1'b0, ex, wt);
        checks++; if (dout !== 32'h9a352e6e) begin errors++; $display("FAIL rfc_dout got=%h exp=9a352e6e", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rfc_dout_valid got=%b exp=1", dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL rfc_dout_last got=%b exp=0", dout_last); end
        for (int i = 1; i < 16; i++) begin
            send_word($urandom, 1'b0, ex, wt);
            checks++; if (dout !== ex) begin errors++; $display("FAIL rfc_word%0d got=%h exp=%h", i, dout, ex); end
        end
        idle(1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rfc_drain got=%b exp=0", dout_valid); end
        checks++; if (words_xored !== st(exp_words)) begin errors++; $display("FAIL rfc_words got=%0d exp=%0d", words_xored, st(exp_words)); end
    endtask

    task automatic test_back_to_back;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt; int unsigned b0;
        b0 = exp_blocks;
        repeat (2) begin
            make_block(pk, w);
            push_block(pk, w);
        end
        checks++; if (ks_ready !== 1'b0) begin errors++; $display("FAIL b2b_both_full ks_ready=%b exp=0", ks_ready); end
        for (int i = 0; i < 32; i++) begin
            send_word($urandom, 1'b0, ex, wt);
            checks++; if (wt !== 0) begin errors++; $display("FAIL b2b_bubble word%0d stalls=%0d exp=0", i, wt); end
            checks++; if (dout !== ex || dout_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_word%0d got=%h/%b exp=%h/1", i, dout, dout_valid, ex);
            end
        end
        idle(1);
        checks++; if (ks_ready !== 1'b1) begin errors++; $display("FAIL b2b_ks_ready got=%b exp=1", ks_ready); end
        checks++; if (blocks_used !== st(exp_blocks) || exp_blocks - b0 != 2) begin
            errors++; $display("FAIL b2b_blocks got=%0d exp=%0d", blocks_used, st(exp_blocks));
        end
        checks++; if (words_xored !== st(exp_words)) begin errors++; $display("FAIL b2b_words got=%0d exp=%0d", words_xored, st(exp_words)); end
    endtask

    task automatic test_last_mid;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt;
        repeat (2) begin
            make_block(pk, w);
            push_block(pk, w);
        end
        for (int i = 0; i < 6; i++) begin
            send_word($urandom, (i == 5), ex, wt);
            checks++; if (dout !== ex || dout_last !== (i == 5)) begin
                errors++; $display("FAIL last_msg1_word%0d got=%h/%b exp=%h/%b", i, dout, dout_last, ex, (i == 5));
            end
        end
        checks++; if (blocks_used !== st(exp_blocks)) begin errors++; $display("FAIL last_blocks got=%0d exp=%0d", blocks_used, st(exp_blocks)); end
        for (int i = 0; i < 16; i++) begin
            send_word($urandom, (i == 15), ex, wt);
            checks++; if (dout !== ex) begin errors++; $display("FAIL last_msg2_word%0d got=%h exp=%h", i, dout, ex); end
        end
        idle(1);
    endtask

    task automatic test_stall;
        pblk_t pk; blk16_t w; logic [31:0] ex; logic [31:0] held; logic [31:0] d6; int wt;
        make_block(pk, w);
        push_block(pk, w);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, ex, wt);
        held = ex;
        checks++; if (dout !== held) begin errors++; $display("FAIL stall_pre got=%h exp=%h", dout, held); end
        d6 = $urandom;
        dout_ready = 1'b0;
        din = d6; din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL stall_din_ready cyc%0d got=%b exp=0", c, din_ready); end
            @(posedge clk);
            #1;
            checks++; if (dout !== held || dout_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc%0d got=%h/%b exp=%h/1", c, dout, dout_valid, held);
            end
        end
        dout_ready = 1'b1;
        for (int i = 5; i < 16; i++) begin
            send_word((i == 5) ? d6 : $urandom, 1'b0, ex, wt);
            checks++; if (dout !== ex) begin errors++; $display("FAIL stall_word%0d got=%h exp=%h", i, dout, ex); end
        end
        idle(1);
        checks++; if (words_xored !== st(exp_words)) begin errors++; $display("FAIL stall_words got=%0d exp=%0d", words_xored, st(exp_words)); end
    endtask

    task automatic test_full;
        pblk_t pk; blk16_t w; pblk_t pk3; blk16_t w3; logic [31:0] ex; int wt;
        repeat (2) begin
            make_block(pk, w);
            push_block(pk, w);
        end
        make_block(pk3, w3);
        ks_block = pk3; ks_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ks_ready !== 1'b0) begin errors++; $display("FAIL full_ks_ready cyc%0d got=%b exp=0", c, ks_ready); end
            @(posedge clk);
            #1;
        end
        ks_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i == 16) push_block(pk3, w3);
            send_word($urandom, 1'b0, ex, wt);
            checks++; if (dout !== ex) begin errors++; $display("FAIL full_word%0d got=%h exp=%h", i, dout, ex); end
        end
        idle(1);
    endtask

    task automatic test_flush;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt;
        make_block(pk, w);
        push_block(pk, w);
        make_block(pk, w);
        flush = 1'b1; ks_block = pk; ks_valid = 1'b1;
        din = $urandom; din_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; ks_valid = 1'b0; din_valid = 1'b0;
        blkq.delete();
        widx = 0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL flush_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (ks_ready !== 1'b1) begin errors++; $display("FAIL flush_ks_ready got=%b exp=1", ks_ready); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL flush_din_ready got=%b exp=0", din_ready); end
        checks++; if (words_xored !== st(exp_words)) begin errors++; $display("FAIL flush_words got=%0d exp=%0d", words_xored, st(exp_words)); end
        make_block(pk, w);
        push_block(pk, w);
        for (int i = 0; i < 16; i++) begin
            send_word($urandom, 1'b0, ex, wt);
            checks++; if (dout !== ex) begin errors++; $display("FAIL flush_after_word%0d got=%h exp=%h", i, dout, ex); end
        end
        idle(1);
    endtask

    task automatic test_random;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt; int len;
        for (int m = 0; m < 4; m++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if (blkq.size() == 0 || (blkq.size() == 1 && $urandom_range(0, 1) == 1)) begin
                    make_block(pk, w);
                    push_block(pk, w);
                end
                send_word($urandom, (i == len - 1), ex, wt);
                checks++; if (dout !== ex || dout_last !== (i == len - 1)) begin
                    errors++; $display("FAIL rand_msg%0d_word%0d got=%h/%b exp=%h/%b", m, i, dout, dout_last, ex, (i == len - 1));
                end
            end
        end
        idle(1);
        checks++; if (blocks_used !== st(exp_blocks)) begin errors++; $display("FAIL rand_blocks got=%0d exp=%0d", blocks_used, st(exp_blocks)); end
        checks++; if (words_xored !== st(exp_words)) begin errors++; $display("FAIL rand_words got=%0d exp=%0d", words_xored, st(exp_words)); end
    endtask

    task automatic test_reset_mid;
        pblk_t pk; blk16_t w; logic [31:0] ex; int wt;
        make_block(pk, w);
        push_block(pk, w);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, ex, wt);
        rst_n = 1'b0;
        #2;
        blkq.delete();
        widx = 0; exp_blocks = 0; exp_words = 0;
        checks++;
        if ({ks_ready, din_ready, dout, dout_valid, dout_last, blocks_used, words_xored}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL midrst_outputs got=%b/%b/%h/%b/%b/%0d/%0d exp=1/0/0/0/0/0/0",
                     ks_ready, din_ready, dout, dout_valid, dout_last, blocks_used, words_xored);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        checks++; if (din_ready !== 1'b0 || ks_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_after got=%b/%b exp=0/1", din_ready, ks_ready);
        end
    endtask

    initial begin
        test_reset;
        test_rfc;
        test_back_to_back;
        test_last_mid;
        test_stall;
        test_full;
        test_flush;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
